control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Instruction sequencer for the 10-bit processor. It captures an instruction on an EXEC press and
//  steps timesteps T0-T3, driving the register/ALU/bus enables for each step.
//  TIME and DONE feed the display/output stage directly. The enables feed the register file, ALU
//  and bus mux.
// PARAMETERS
//  DW    10  instruction width; the encoding below is defined only for 10
//  NREG  4   number of general registers; the encoding below is defined only for 4
// PORTS
//  CLK      in   1   system clock, rising edge
//  RSTb     in   1   asynchronous active-low reset
//  EXEC     in   1   debounced execute button, active high, level
//  CLR      in   1   synchronous abort back to T0, active high
//  INSTR    in   DW  instruction from switches: [9:6] OP, [5:4] RX, [3:2] RY, [1:0] ignored
//  EXTRN    out  1   drive external data (INSTR) onto BUS
//  RIN      out  4   one-hot register load enable
//  ROUT     out  4   one-hot register drive-to-BUS enable
//  AIN      out  1   load ALU A latch from BUS
//  GIN      out  1   load ALU result register G
//  GOUT     out  1   drive G onto BUS
//  ALU_OP   out  4   ALU function, equal to IR[9:6]
//  TIME     out  2   current timestep (0..3)
//  DONE     out  1   high during the final step of an instruction
// BEHAVIOUR
//  State registers and their reset values (RSTb=0):
//   - TIME=0, IR=0, EXEC_q=0.
//   - All outputs therefore read 0 out of reset. Reset is legal at any step and aborts the instruction.
//  Start condition:
//   - start = EXEC & ~EXEC_q & (TIME==0) & ~CLR. EXEC_q is EXEC registered every cycle.
//   - On start: IR<=INSTR and TIME<=1.
//   - Holding EXEC high starts exactly one instruction. A rising edge of EXEC while TIME!=0 is ignored.
//  CLR:
//   - At the next edge TIME<=0; IR is held.
//   - CLR beats start and beats DONE.
//  Step advance:
//   - If DONE=1, TIME<=0 at the next edge.
//   - Otherwise, when TIME!=0, TIME<=TIME+1.
//   - TIME never wraps from 3 to 0 except via DONE, CLR or reset.
//  Output timing:
//   - All enables and DONE are a combinational decode of (TIME, IR) only, so there is no
//     combinational path from EXEC, CLR or INSTR to any output.
//   - Decoded outputs are 0 in T0. ALU_OP = IR[9:6] at all times.
//  Opcode decode (RX = one-hot of IR[5:4], RY = one-hot of IR[3:2]):
//   - 0000 LOAD: T1 EXTRN, RIN=RX, DONE.
//   - 0001 COPY: T1 ROUT=RY, RIN=RX, DONE.
//   - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR:
//     T1 ROUT=RX, AIN; T2 ROUT=RY, GIN; T3 GOUT, RIN=RX, DONE.
//   - 0111 INV: T1 ROUT=RX, AIN; T2 GIN (BUS undriven); T3 GOUT, RIN=RX, DONE.
//   - 1000-1111 (illegal): T1 DONE only, no enables; the instruction is a NOP.
//  Latency: LOAD, COPY and NOP take 2 cycles from start to T0; ALU ops take 4 cycles.
//  Invariants:
//   - At most one of {EXTRN, GOUT, any ROUT bit} is high in any cycle.
//   - RIN and ROUT are each zero or one-hot.
//   - DONE is high for exactly one cycle per started instruction, unless CLR or reset aborts it first.
//   - RX==RY is legal (COPY R1,R1; ADD R2,R2 doubles R2).
// TESTING
//  1. Reset, then LOAD: release RSTb; INSTR=10'b0000_10_00_00, pulse EXEC
//     -> T1: EXTRN=1, RIN=0100, DONE=1; next cycle TIME=0 and all enables 0.
//  2. ADD R1,R3: INSTR=10'b0010_01_11_00, pulse EXEC
//     -> T1 ROUT=0010,AIN; T2 ROUT=1000,GIN,ALU_OP=0010; T3 GOUT,RIN=0010,DONE; then TIME=0.
//  3. Hold EXEC high 10 cycles with COPY R0,R2 (INSTR=10'b0001_00_10_00)
//     -> exactly one DONE pulse; TIME stays 0 afterward until EXEC falls and rises again.
//  4. Start SUB; assert CLR in T2
//     -> TIME=0 next edge, RIN never asserted, DONE never high; EXEC and CLR in the same T0 cycle -> no start.
//  5. Illegal opcode 1010 -> T1 DONE=1 with RIN=ROUT=0; and in a separate run, drop RSTb mid-T2
//     of XOR -> TIME=0 and all outputs 0 immediately, without waiting for CLK.
//  6. Every scenario: checker asserts the bus-driver exclusivity and one-hot invariants each cycle.

Source files
------------

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Instruction sequencer for the 10-bit processor. An EXEC rising edge in T0
//   captures INSTR into IR and walks the timesteps T1..T3. The register, ALU
//   and bus enables are decoded from (TIME, IR) only. Because of this, EXEC,
//   CLR and INSTR affect the outputs only through registers.
//
//   Handshake: there is no valid/ready pair. The protocol is as follows.
//     - An EXEC level that rises while TIME==0 and CLR==0 starts one
//       instruction.
//     - DONE marks the last step of that instruction.
//     - CLR aborts the instruction on the next edge.
//
// Ports
//   CLK     in   1     system clock, rising edge
//   RSTb    in   1     asynchronous active-low reset
//   EXEC    in   1     debounced execute button, level
//   CLR     in   1     synchronous abort back to T0
//   INSTR   in   DW    [9:6] OP, [5:4] RX, [3:2] RY, [1:0] unused
//   EXTRN   out  1     drive INSTR onto BUS
//   RIN     out  NREG  one-hot register load enable
//   ROUT    out  NREG  one-hot register drive-to-BUS enable
//   AIN     out  1     load ALU A latch from BUS
//   GIN     out  1     load ALU result register G
//   GOUT    out  1     drive G onto BUS
//   ALU_OP  out  4     ALU function (IR[9:6])
//   TIME    out  2     current timestep; this is also the FSM state
//   DONE    out  1     final step of the instruction
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int DW   = 10,
  parameter int NREG = 4
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic            EXEC,
  input  logic            CLR,
  input  logic [DW-1:0]   INSTR,
  output logic            EXTRN,
  output logic [NREG-1:0] RIN,
  output logic [NREG-1:0] ROUT,
  output logic            AIN,
  output logic            GIN,
  output logic            GOUT,
  output logic [3:0]      ALU_OP,
  output logic [1:0]      TIME,
  output logic            DONE
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;
  localparam logic [3:0] OP_INV  = 4'b0111;

  step_t         state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          exec_q;

  logic [3:0]      op;
  logic [NREG-1:0] rx_oh;
  logic [NREG-1:0] ry_oh;
  logic            is_alu;
  logic            start;
  logic            unused_ir_bits;

  // State register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= T0;
      ir_q    <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      exec_q  <= EXEC;
    end
  end

  // Instruction field decode.
  assign op     = ir_q[DW-1:DW-4];
  assign rx_oh  = NREG'(1) << ir_q[DW-5:DW-6];
  assign ry_oh  = NREG'(1) << ir_q[DW-7:DW-8];
  // Opcodes 0010..0111 are the three-step ALU group; 1xxx is illegal.
  assign is_alu = (op[3] == 1'b0) && (op[2:1] != 2'b00);

  assign unused_ir_bits = ^ir_q[DW-9:0];

  // Edge detect on EXEC, so holding the button runs only one instruction.
  assign start = EXEC & ~exec_q & (state_q == T0) & ~CLR;

  // Next state. The priority order is CLR, then start, then DONE, then step.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (CLR) begin
      state_d = T0;
    end else if (start) begin
      state_d = T1;
      ir_d    = INSTR;
    end else if (DONE) begin
      state_d = T0;
    end else begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        // T3 always has DONE for a legal decode. The hold is here so that
        // the counter never wraps on its own.
        T3:      state_d = T3;
        default: state_d = T0;
      endcase
    end
  end

  // Output decode of (TIME, IR). All outputs are quiet in T0.
  always_comb begin
    EXTRN = 1'b0;
    RIN   = '0;
    ROUT  = '0;
    AIN   = 1'b0;
    GIN   = 1'b0;
    GOUT  = 1'b0;
    DONE  = 1'b0;
    case (state_q)
      T1: begin
        if (op == OP_LOAD) begin
          EXTRN = 1'b1;
          RIN   = rx_oh;
          DONE  = 1'b1;
        end else if (op == OP_COPY) begin
          ROUT  = ry_oh;
          RIN   = rx_oh;
          DONE  = 1'b1;
        end else if (is_alu) begin
          ROUT  = rx_oh;
          AIN   = 1'b1;
        end else begin
          // An illegal opcode retires as a one-step NOP.
          DONE  = 1'b1;
        end
      end
      T2: begin
        if (is_alu) begin
          GIN = 1'b1;
          // INV has a single operand, so the bus stays undriven.
          if (op != OP_INV) ROUT = ry_oh;
        end
      end
      T3: begin
        if (is_alu) begin
          GOUT = 1'b1;
          RIN  = rx_oh;
          DONE = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ALU_OP = op;
  assign TIME   = state_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       RSTb;
  logic       EXEC;
  logic       CLR;
  logic [9:0] INSTR;
  logic       EXTRN;
  logic [3:0] RIN;
  logic [3:0] ROUT;
  logic       AIN;
  logic       GIN;
  logic       GOUT;
  logic [3:0] ALU_OP;
  logic [1:0] TIME;
  logic       DONE;

  int checks   = 0;
  int failures = 0;

  control_unit #(.DW(10), .NREG(4)) dut (
    .CLK    (CLK),
    .RSTb   (RSTb),
    .EXEC   (EXEC),
    .CLR    (CLR),
    .INSTR  (INSTR),
    .EXTRN  (EXTRN),
    .RIN    (RIN),
    .ROUT   (ROUT),
    .AIN    (AIN),
    .GIN    (GIN),
    .GOUT   (GOUT),
    .ALU_OP (ALU_OP),
    .TIME   (TIME),
    .DONE   (DONE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed view of all outputs: {EXTRN,RIN,ROUT,AIN,GIN,GOUT,ALU_OP,TIME,DONE}.
  function automatic logic [18:0] pack_out(logic ex, logic [3:0] ri, logic [3:0] ro,
                                           logic a, logic gi, logic go,
                                           logic [3:0] alu, logic [1:0] t, logic d);
    return {ex, ri, ro, a, gi, go, alu, t, d};
  endfunction

  // ---------------- behavioural model ----------------
  // The instruction is a list of micro-steps. The model tracks which step is
  // active, and the length of that list decides when the instruction ends.
  function automatic int steps_of(logic [3:0] op);
    if (op >= 4'd2 && op <= 4'd7) return 3;
    return 1;
  endfunction

  function automatic logic [18:0] model_out(logic [9:0] ir, int step);
    logic [3:0] op;
    logic [3:0] rx;
    logic [3:0] ry;
    logic       ex, a, gi, go, d;
    logic [3:0] ri, ro;
    op = ir[9:6];
    rx = 4'b0001 << ir[5:4];
    ry = 4'b0001 << ir[3:2];
    ex = 0; a = 0; gi = 0; go = 0; d = 0; ri = 0; ro = 0;
    if (step != 0) begin
      if (op == 4'd0) begin
        ex = 1; ri = rx; d = 1;
      end else if (op == 4'd1) begin
        ro = ry; ri = rx; d = 1;
      end else if (op >= 4'd8) begin
        d = 1;
      end else begin
        if (step == 1) begin ro = rx; a = 1; end
        if (step == 2) begin gi = 1; ro = (op == 4'd7) ? 4'b0000 : ry; end
        if (step == 3) begin go = 1; ri = rx; d = 1; end
      end
    end
    return pack_out(ex, ri, ro, a, gi, go, op, 2'(step), d);
  endfunction

  logic [9:0] m_ir   = '0;
  int         m_step = 0;
  logic       m_prev = 1'b0;

  always @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      m_ir   <= '0;
      m_step <= 0;
      m_prev <= 1'b0;
    end else begin
      if (CLR) m_step <= 0;
      else if (m_step == 0) begin
        if (EXEC && !m_prev) begin
          m_ir   <= INSTR;
          m_step <= 1;
        end
      end else if (m_step == steps_of(m_ir[9:6])) m_step <= 0;
      else m_step <= m_step + 1;
      m_prev <= EXEC;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("cycle_outputs",
        pack_out(EXTRN, RIN, ROUT, AIN, GIN, GOUT, ALU_OP, TIME, DONE),
        model_out(m_ir, m_step));
    chk("bus_exclusive", (32'(EXTRN) + 32'(GOUT) + 32'($countones(ROUT))) <= 1, 1);
    chk("rin_onehot0", $onehot0(RIN), 1);
    chk("rout_onehot0", $onehot0(ROUT), 1);
  end

  // ---------------- driver ----------------
  // Each tick moves to just after a rising edge. At that point the new state
  // is visible on the outputs and new inputs can be applied.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  int  dones;
  int  n;
  logic rin_seen, done_seen;

  initial begin
    RSTb  = 1'b0;
    EXEC  = 1'b0;
    CLR   = 1'b0;
    INSTR = '0;
    tick(); tick();
    chk("reset_outputs",
        pack_out(EXTRN, RIN, ROUT, AIN, GIN, GOUT, ALU_OP, TIME, DONE), 19'd0);

    // 1. LOAD R2
    RSTb = 1'b1;
    tick();
    INSTR = 10'b0000_10_00_00;
    EXEC  = 1'b1;
    tick();
    chk("load_t1_time", TIME, 2'd1);
    chk("load_t1_extrn", EXTRN, 1'b1);
    chk("load_t1_rin", RIN, 4'b0100);
    chk("load_t1_done", DONE, 1'b1);
    EXEC = 1'b0;
    tick();
    chk("load_after",
        pack_out(EXTRN, RIN, ROUT, AIN, GIN, GOUT, ALU_OP, TIME, DONE), 19'd0);

    // 2. ADD R1,R3
    tick();
    INSTR = 10'b0010_01_11_00;
    EXEC  = 1'b1;
    tick();
    chk("add_t1_rout", ROUT, 4'b0010);
    chk("add_t1_ain", AIN, 1'b1);
    EXEC = 1'b0;
    tick();
    chk("add_t2_rout", ROUT, 4'b1000);
    chk("add_t2_gin", GIN, 1'b1);
    chk("add_t2_aluop", ALU_OP, 4'b0010);
    tick();
    chk("add_t3_gout", GOUT, 1'b1);
    chk("add_t3_rin", RIN, 4'b0010);
    chk("add_t3_done", DONE, 1'b1);
    tick();
    chk("add_after_time", TIME, 2'd0);

    // 3. COPY R0,R2 with EXEC held high
    INSTR = 10'b0001_00_10_00;
    EXEC  = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (DONE) dones++;
    end
    chk("hold_one_done", 32'(dones), 32'd1);
    chk("hold_time_idle", TIME, 2'd0);
    EXEC = 1'b0;
    tick();
    EXEC = 1'b1;
    tick();
    chk("copy_restart_time", TIME, 2'd1);
    chk("copy_rout", ROUT, 4'b0100);
    chk("copy_rin", RIN, 4'b0001);
    EXEC = 1'b0;
    tick();

    // 4. SUB aborted by CLR in T2, then EXEC+CLR together in T0
    INSTR     = 10'b0011_01_10_00;
    EXEC      = 1'b1;
    rin_seen  = 1'b0;
    done_seen = 1'b0;
    tick();
    rin_seen |= |RIN; done_seen |= DONE;
    EXEC = 1'b0;
    tick();
    chk("sub_in_t2", TIME, 2'd2);
    rin_seen |= |RIN; done_seen |= DONE;
    CLR = 1'b1;
    tick();
    rin_seen |= |RIN; done_seen |= DONE;
    chk("clr_time", TIME, 2'd0);
    chk("clr_no_rin", rin_seen, 1'b0);
    chk("clr_no_done", done_seen, 1'b0);
    EXEC = 1'b1;
    tick();
    chk("clr_beats_start", TIME, 2'd0);
    CLR = 1'b0;
    tick();
    chk("no_start_held_exec", TIME, 2'd0);
    EXEC = 1'b0;
    tick();

    // 5a. Illegal opcode 1010
    INSTR = 10'b1010_11_01_00;
    EXEC  = 1'b1;
    tick();
    chk("illegal_done", DONE, 1'b1);
    chk("illegal_rin", RIN, 4'b0000);
    chk("illegal_rout", ROUT, 4'b0000);
    chk("illegal_aluop", ALU_OP, 4'b1010);
    EXEC = 1'b0;
    tick();
    chk("illegal_back_t0", TIME, 2'd0);

    // 5b. XOR interrupted by reset mid-T2
    INSTR = 10'b0110_10_01_00;
    EXEC  = 1'b1;
    tick();
    EXEC = 1'b0;
    tick();
    chk("xor_in_t2", TIME, 2'd2);
    #1 RSTb = 1'b0;
    #1;
    chk("async_reset_outputs",
        pack_out(EXTRN, RIN, ROUT, AIN, GIN, GOUT, ALU_OP, TIME, DONE), 19'd0);
    tick();
    RSTb = 1'b1;
    tick();

    // Sweep every opcode and check that each one returns to T0 in time.
    for (int op = 0; op < 16; op++) begin
      INSTR = {4'(op), 2'(op % 4), 2'((op + 1) % 4), 2'b11};
      EXEC  = 1'b1;
      tick();
      EXEC = 1'b0;
      n = 1;
      while (TIME != 2'd0 && n < 8) begin
        tick();
        n++;
      end
      chk("op_latency", 32'(n), (op >= 2 && op <= 7) ? 32'd4 : 32'd2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
